// File: rtl/activity_tracker_core.sv
// activity_tracker_core: single-clock pedometer core.
// Synchronizes a raw step strobe, derives its own 1 s tick, accumulates
// step/distance/low-window/high-activity metrics and rotates them onto
// four registered BCD digits for a seven-segment driver.
module activity_tracker_core #(
    parameter int unsigned CLK_HZ              = 100_000_000,
    parameter int unsigned CNT_W               = 32,
    parameter int unsigned STEPS_PER_HALF_MILE = 1024,
    parameter int unsigned LOW_THRESH          = 32,
    parameter int unsigned WINDOW_SECS         = 9,
    parameter int unsigned HIGH_THRESH         = 64,
    parameter int unsigned MIN_RUN_SECS        = 60,
    parameter int unsigned DISP_SECS           = 2
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic       step_in,
    input  logic       hold,
    output logic       si,
    output logic [1:0] mode,
    output logic [4:0] bcd3,
    output logic [4:0] bcd2,
    output logic [4:0] bcd1,
    output logic [4:0] bcd0,
    output logic [7:0] steps_per_sec,
    output logic       sec_tick
);
    localparam int unsigned      PW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [CNT_W-1:0] CMAX = '1;

    typedef enum logic [1:0] {M_STEPS = 2'd0, M_DIST = 2'd1, M_LOW = 2'd2, M_HIGH = 2'd3} mode_e;

    logic [2:0]       sync;
    logic             step_p;
    logic [PW-1:0]    presc;
    logic [CNT_W-1:0] sec_steps, total, dist_sub, half_miles;
    logic [CNT_W-1:0] win_idx, low_cnt, run, high_time;
    logic [CNT_W-1:0] dwell, dwell_nx;
    mode_e            state, state_nx;
    logic [13:0]      src;
    logic [15:0]      dd;
    logic [4:0]       dig3, dig2, dig1, dig0;

    // Unsigned add that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] v, input logic [CNT_W-1:0] d);
        logic [CNT_W:0] s;
        s = {1'b0, v} + {1'b0, d};
        return s[CNT_W] ? CMAX : s[CNT_W-1:0];
    endfunction

    // Four digits cannot show more than 9999, so larger values pin there.
    function automatic logic [13:0] clamp(input logic [CNT_W-1:0] v);
        return (v > CNT_W'(9999)) ? 14'd9999 : 14'(v);
    endfunction

    // Shift-add-3 conversion of a value <= 9999 into four BCD nibbles.
    function automatic logic [15:0] bin2bcd(input logic [13:0] b);
        logic [15:0] d;
        d = '0;
        for (int i = 13; i >= 0; i--) begin
            for (int k = 0; k < 4; k++)
                if (d[4*k +: 4] >= 4'd5) d[4*k +: 4] = d[4*k +: 4] + 4'd3;
            d = {d[14:0], b[i]};
        end
        return d;
    endfunction

    // Two-flop synchronizer plus a history flop for rising-edge detection.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) sync <= '0;
        else       sync <= {sync[1:0], step_in};
    end
    assign step_p = sync[1] & ~sync[2];

    // Free-running prescaler; the last count of each second is the tick.
    assign sec_tick = (presc == PW'(CLK_HZ - 1));
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) presc <= '0;
        else       presc <= sec_tick ? '0 : presc + 1'b1;
    end

    // Raw step counters; a step landing on the tick opens the new second.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            sec_steps  <= '0;
            total      <= '0;
            dist_sub   <= '0;
            half_miles <= '0;
        end else begin
            if (sec_tick)    sec_steps <= step_p ? CNT_W'(1) : '0;
            else if (step_p) sec_steps <= sat_add(sec_steps, CNT_W'(1));
            if (step_p) begin
                total <= sat_add(total, CNT_W'(1));
                if (dist_sub == CNT_W'(STEPS_PER_HALF_MILE - 1)) begin
                    dist_sub   <= '0;
                    half_miles <= sat_add(half_miles, CNT_W'(1));
                end else begin
                    dist_sub <= dist_sub + 1'b1;
                end
            end
        end
    end

    // Per-second scoring using the count of the second that just ended.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            steps_per_sec <= '0;
            win_idx       <= '0;
            low_cnt       <= '0;
            run           <= '0;
            high_time     <= '0;
        end else if (sec_tick) begin
            steps_per_sec <= (sec_steps > CNT_W'(255)) ? 8'hFF : 8'(sec_steps);
            if (win_idx < CNT_W'(WINDOW_SECS)) begin
                win_idx <= win_idx + 1'b1;
                if (sec_steps > CNT_W'(LOW_THRESH)) low_cnt <= low_cnt + 1'b1;
            end
            if (sec_steps >= CNT_W'(HIGH_THRESH)) begin
                run <= sat_add(run, CNT_W'(1));
                // The qualifying run is credited retroactively once it reaches the minimum.
                if (run == CNT_W'(MIN_RUN_SECS - 1))
                    high_time <= sat_add(high_time, CNT_W'(MIN_RUN_SECS));
                else if (run >= CNT_W'(MIN_RUN_SECS))
                    high_time <= sat_add(high_time, CNT_W'(1));
            end else begin
                run <= '0;
            end
        end
    end

    // Display mode and dwell registers.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state <= M_STEPS;
            dwell <= '0;
        end else begin
            state <= state_nx;
            dwell <= dwell_nx;
        end
    end

    // Dwell counts unheld ticks; the DISP_SECS-th one rotates the mode.
    always_comb begin
        state_nx = state;
        dwell_nx = dwell;
        if (sec_tick && !hold) begin
            if (dwell == CNT_W'(DISP_SECS - 1)) begin
                dwell_nx = '0;
                case (state)
                    M_STEPS: state_nx = M_DIST;
                    M_DIST:  state_nx = M_LOW;
                    M_LOW:   state_nx = M_HIGH;
                    default: state_nx = M_STEPS;
                endcase
            end else begin
                dwell_nx = dwell + 1'b1;
            end
        end
    end
    assign mode = state;

    // Select the metric for the current mode and convert it to digits.
    always_comb begin
        case (state)
            M_STEPS: src = clamp(total);
            M_DIST:  src = 14'((half_miles >> 1) % CNT_W'(100));
            M_LOW:   src = clamp(low_cnt);
            default: src = clamp(high_time);
        endcase
        dd   = bin2bcd(src);
        dig3 = {1'b0, dd[15:12]};
        dig2 = {1'b0, dd[11:8]};
        dig1 = {1'b0, dd[7:4]};
        dig0 = {1'b0, dd[3:0]};
        // Distance reads as whole miles, a blank, then the half-mile digit.
        if (state == M_DIST) begin
            dig3 = {1'b0, dd[7:4]};
            dig2 = {1'b0, dd[3:0]};
            dig1 = 5'h1F;
            dig0 = half_miles[0] ? 5'd5 : 5'd0;
        end
    end

    // Registered display digits and step-overflow indicator.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            {bcd3, bcd2, bcd1, bcd0} <= '0;
            si <= 1'b0;
        end else begin
            {bcd3, bcd2, bcd1, bcd0} <= {dig3, dig2, dig1, dig0};
            si <= (total > CNT_W'(9999));
        end
    end
endmodule
